fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BUF_DEPTH, 2, instruction buffer entries; power of two, at least 2.
REQ-002 Port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 Port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 Port en_i  input  1  fetch enable; new requests are issued only while high.
REQ-005 Port flush_i  input  1  discard all buffered and in-flight instructions.
REQ-006 Port pc_i  input  32  current PC from the program counter block.
REQ-007 Port incr_pc_o  output  1  single-cycle pulse that advances the PC by 4.
REQ-008 Port req_valid_o  output  1  instruction memory request valid.
REQ-009 Port req_addr_o  output  32  instruction memory request address.
REQ-010 Port req_ready_i  input  1  memory accepts the request.
REQ-011 Port rsp_valid_i  input  1  memory response valid, one cycle, no backpressure.
REQ-012 Port rsp_data_i  input  32  memory response instruction word.
REQ-013 Port instr_valid_o  output  1  buffer head valid toward decode.
REQ-014 Port instr_o  output  32  buffer head instruction.
REQ-015 Port instr_pc_o  output  32  PC of the buffer head instruction.
REQ-016 Port instr_ready_i  input  1  decode consumes the head when high together with instr_valid_o.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and WAIT. At most one request is outstanding.
REQ-018 IDLE -> REQ SHALL occur when en_i=1 and count < BUF_DEPTH; otherwise the FSM stays in IDLE.
REQ-019 REQ behaviour:
- req_valid_o=1 and req_addr_o=pc_i.
- Address and valid stay stable until req_ready_i=1, regardless of en_i or flush_i.
REQ-020 REQ handshake cycle (req_valid_o=1 and req_ready_i=1):
- incr_pc_o=1 for exactly that cycle.
- The request PC is captured into pend_pc_q.
- The FSM moves to WAIT.
REQ-021 incr_pc_o SHALL be 0 in every other cycle.
REQ-022 WAIT with rsp_valid_i=1:
- If drop_q=0, push {pend_pc_q, rsp_data_i}; if drop_q=1, discard the response.
- Clear drop_q.
- Go to REQ if en_i=1 and post-update count < BUF_DEPTH, else go to IDLE.
REQ-023 rsp_valid_i outside WAIT SHALL be ignored.
REQ-024 Buffer behaviour:
- FIFO ordering; the head drives instr_o and instr_pc_o.
- instr_valid_o = (count != 0).
- A push is visible on the outputs the cycle after rsp_valid_i (1-cycle latency).
REQ-025 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order. Read and write pointers wrap modulo BUF_DEPTH.
REQ-026 A push SHALL never occur when count = BUF_DEPTH. This is guaranteed by the REQ-018/REQ-022 issue rule, which checks count before issuing.
REQ-027 flush_i=1 SHALL:
- Empty the buffer next cycle (count=0, pointers reset, pop ignored).
- Set drop_q=1 if the FSM is in REQ or WAIT.
- Flush has priority over a same-cycle push or pop.
REQ-028 A flush in WAIT in the same cycle as rsp_valid_i SHALL discard that response and leave drop_q=0.
REQ-029 en_i deassertion SHALL NOT abort an outstanding request or response. It only blocks the next issue.

Reset
REQ-030 Asserting rst_n_i low SHALL immediately and asynchronously force:
- FSM=IDLE, count=0, pointers=0, drop_q=0, pend_pc_q=0.
- incr_pc_o=0, req_valid_o=0, instr_valid_o=0.
- req_addr_o follows pc_i; instr_o=0, instr_pc_o=0.
REQ-031 Reset mid-request SHALL abandon the transaction. Any later rsp_valid_i is ignored because the FSM is in IDLE.

Verification
REQ-032 Reset then en_i=1, pc_i=0x0, req_ready_i=1, response 2 cycles later with data 0xA:
- req_addr_o=0x0 and incr_pc_o pulses once.
- instr_valid_o=1 with instr_o=0xA, instr_pc_o=0x0 the cycle after the response.
REQ-033 instr_ready_i=0, BUF_DEPTH=2, responses 0x11 and 0x22:
- After two fetches no third req_valid_o is issued.
- One pop re-enables issue, and the next address is 0x8.
REQ-034 req_ready_i held 0 for 5 cycles:
- req_valid_o stays 1 with constant req_addr_o.
- incr_pc_o stays 0 until acceptance.
REQ-035 flush_i during WAIT with 1 buffered entry:
- instr_valid_o=0 next cycle.
- The subsequent response 0xDEAD is not pushed.
- The following fetch is pushed normally.
REQ-036 Simultaneous pop and push at count=1:
- count stays 1 and the new entry becomes head.
- Covers pointer wrap over 4 or more consecutive fetches.
REQ-037 rst_n_i low in WAIT, then a response arrives:
- Outputs are at reset values and nothing is pushed.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time and
// buffers returned instruction words with their PCs in a small FIFO toward decode.
module fetch_ctrl #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic        incr_pc_o,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          drop_q, drop_d;
  logic [31:0]   pend_pc_q, pend_pc_d;

  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];

  logic          handshake;
  logic          push;
  logic          pop;

  always_comb begin
    handshake = (state_q == REQ) && req_ready_i;
    push      = (state_q == WAIT) && rsp_valid_i && !drop_q && !flush_i;
    pop       = (count_q != '0) && instr_ready_i && !flush_i;

    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    drop_d    = drop_q;
    pend_pc_d = pend_pc_q;
    state_d   = state_q;

    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // A response arriving in WAIT always clears drop, even alongside a flush:
    // the flush already discards that response, so nothing is left to drop.
    if ((state_q == WAIT) && rsp_valid_i) begin
      drop_d = 1'b0;
    end else if (flush_i && (state_q != IDLE)) begin
      drop_d = 1'b1;
    end

    if (handshake) pend_pc_d = pc_i;

    case (state_q)
      IDLE: begin
        if (en_i && (count_q < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_valid_i) begin
          state_d = (en_i && (count_d < DEPTH_C)) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      drop_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      drop_q    <= drop_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr_q[wptr_q] <= rsp_data_i;
      buf_pc_q[wptr_q]    <= pend_pc_q;
    end
  end

  assign incr_pc_o     = handshake;
  assign req_valid_o   = (state_q == REQ);
  assign req_addr_o    = pc_i;
  assign instr_valid_o = (count_q != '0);
  // Head is gated by valid so the outputs read zero out of reset.
  assign instr_o       = instr_valid_o ? buf_instr_q[rptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? buf_pc_q[rptr_q]    : '0;

endmodule
